// File: rtl/modu_init_req_ctrl.sv
// Init-value request and strobe sequencer for one decoder half-iteration.
// Optional macro INIT_REQ_CNT_EN adds the iter_cnt output (completed half-iterations).
module modu_init_req_ctrl #(
  parameter int WIN_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decMode,
  input  logic [3:0]  decNum,
  input  logic [3:0]  q_up,
  output logic        FPU_Init_Req,
  output logic        BPU_Init_Req,
  output logic        Updata_BPUtail_beta,
  output logic        Updata_BPU_beta,
  output logic        Updata_BPUtail_beta_delay,
  output logic        Updata_FPU_alpha,
  output logic        Updata_FPU_alpha_delay,
  output logic        fpu_load,
  output logic        bpu_load,
  output logic        busy,
`ifdef INIT_REQ_CNT_EN
  output logic [15:0] iter_cnt,
`endif
  output logic        done
);

  localparam int SW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(WIN_LEN - 1);
  localparam logic [SW-1:0] STEP_TAIL = SW'(WIN_LEN - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_FREQ, S_BREQ, S_RUN, S_ALPHA, S_DONE
  } state_t;

  state_t          r_state, w_state_next;
  logic [SW-1:0]   r_step, w_step_next;
  logic [3:0]      r_win, w_win_next;
  logic [3:0]      r_qup, w_qup_next;

  logic r_fpu_req, r_bpu_req, r_tail, r_beta, r_tail_dly, r_alpha, r_alpha_dly;
  logic r_fpu_req_d, r_bpu_req_d, r_fpu_load, r_bpu_load, r_busy, r_done;
  logic w_fpu_req, w_bpu_req, w_tail, w_beta, w_tail_dly, w_alpha, w_alpha_dly;
  logic w_busy, w_done, w_in_run;

  // Mode and unit count only travel alongside the request; the sequence ignores them.
  logic w_unused_ctx;
  assign w_unused_ctx = ^{decMode, decNum};

  always_comb begin
    w_state_next = r_state;
    w_step_next  = r_step;
    w_win_next   = r_win;
    w_qup_next   = r_qup;
    unique case (r_state)
      S_IDLE: if (start) begin
        w_state_next = S_FREQ;
        w_step_next  = '0;
        w_win_next   = '0;
        w_qup_next   = q_up;
      end
      S_FREQ: w_state_next = S_BREQ;
      S_BREQ: w_state_next = S_RUN;
      S_RUN: begin
        if (r_step == STEP_LAST) begin
          w_step_next = '0;
          if (r_win == r_qup) w_state_next = S_ALPHA;
          else                w_win_next   = 4'(r_win + 4'd1);
        end else begin
          w_step_next = SW'(r_step + 1'b1);
        end
      end
      S_ALPHA: w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so the registered copies line up with it.
  always_comb begin
    w_in_run    = (w_state_next == S_RUN);
    w_fpu_req   = (w_state_next == S_FREQ);
    w_bpu_req   = (w_state_next == S_BREQ) ||
                  (w_in_run && w_step_next == '0 && w_win_next != 4'd0);
    w_tail      = w_in_run && w_win_next == 4'd0 && w_step_next == STEP_TAIL;
    w_beta      = w_in_run && w_step_next == STEP_LAST;
    w_tail_dly  = w_beta && w_win_next == 4'd0;
    w_alpha     = w_beta && w_win_next == w_qup_next;
    w_alpha_dly = (w_state_next == S_ALPHA);
    w_done      = (w_state_next == S_DONE);
    w_busy      = (w_state_next != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_step      <= '0;
      r_win       <= '0;
      r_qup       <= '0;
      r_fpu_req   <= 1'b0;
      r_bpu_req   <= 1'b0;
      r_tail      <= 1'b0;
      r_beta      <= 1'b0;
      r_tail_dly  <= 1'b0;
      r_alpha     <= 1'b0;
      r_alpha_dly <= 1'b0;
      r_fpu_req_d <= 1'b0;
      r_bpu_req_d <= 1'b0;
      r_fpu_load  <= 1'b0;
      r_bpu_load  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_step      <= w_step_next;
      r_win       <= w_win_next;
      r_qup       <= w_qup_next;
      r_fpu_req   <= w_fpu_req;
      r_bpu_req   <= w_bpu_req;
      r_tail      <= w_tail;
      r_beta      <= w_beta;
      r_tail_dly  <= w_tail_dly;
      r_alpha     <= w_alpha;
      r_alpha_dly <= w_alpha_dly;
      r_fpu_req_d <= r_fpu_req;
      r_bpu_req_d <= r_bpu_req;
      r_fpu_load  <= r_fpu_req_d;
      r_bpu_load  <= r_bpu_req_d;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

`ifdef INIT_REQ_CNT_EN
  logic [15:0] r_iter_cnt;
  always_ff @(posedge clk) begin
    if (rst)         r_iter_cnt <= '0;
    else if (r_done) r_iter_cnt <= r_iter_cnt + 16'd1;
  end
  assign iter_cnt = r_iter_cnt;
`endif

  assign FPU_Init_Req              = r_fpu_req;
  assign BPU_Init_Req              = r_bpu_req;
  assign Updata_BPUtail_beta       = r_tail;
  assign Updata_BPU_beta           = r_beta;
  assign Updata_BPUtail_beta_delay = r_tail_dly;
  assign Updata_FPU_alpha          = r_alpha;
  assign Updata_FPU_alpha_delay    = r_alpha_dly;
  assign fpu_load                  = r_fpu_load;
  assign bpu_load                  = r_bpu_load;
  assign busy                      = r_busy;
  assign done                      = r_done;

endmodule

// File: tb/tb_modu_init_req_ctrl.sv
// Scoreboard bench: a cycle-timing model predicts every output vector of each accepted run.
module tb_modu_init_req_ctrl;
  localparam int L = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic decMode = 1'b0;
  logic [3:0] decNum = 4'd1;
  logic [3:0] q_up = 4'd0;
  logic fpu_req, bpu_req, tail, beta, tail_dly, alpha, alpha_dly, fpu_load, bpu_load, busy, done;
`ifdef INIT_REQ_CNT_EN
  logic [15:0] iter_cnt;
  int model_iter = 0;
`endif

  modu_init_req_ctrl #(.WIN_LEN(L)) dut (
    .clk(clk), .rst(rst), .start(start), .decMode(decMode), .decNum(decNum), .q_up(q_up),
    .FPU_Init_Req(fpu_req), .BPU_Init_Req(bpu_req),
    .Updata_BPUtail_beta(tail), .Updata_BPU_beta(beta),
    .Updata_BPUtail_beta_delay(tail_dly), .Updata_FPU_alpha(alpha),
    .Updata_FPU_alpha_delay(alpha_dly), .fpu_load(fpu_load), .bpu_load(bpu_load),
    .busy(busy),
`ifdef INIT_REQ_CNT_EN
    .iter_cnt(iter_cnt),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [10:0] vec;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int free_from = 0;
  bit mon_en = 1'b0;
  logic [10:0] mon_vec;

  // Init request for the BPU: in BREQ, and at the first step of every later window.
  function automatic bit bpu_req_at(int c, int t, int q);
    return (c == t + 2) || (c > t + 3 && c <= t + 2 + (q + 1) * L && (c - t - 3) % L == 0);
  endfunction

  function automatic logic [10:0] exp_vec(int c, int t, int q);
    int run0 = t + 3;
    int last = t + 2 + (q + 1) * L;
    int dn   = t + 4 + (q + 1) * L;
    bit b_beta = (c >= run0 && c <= last && (c - run0) % L == L - 1);
    return {c == t + 1, bpu_req_at(c, t, q), c == run0 + L - 2, b_beta,
            b_beta && (c - run0) < L, c == last, c == dn - 1,
            c == t + 3, bpu_req_at(c - 2, t, q), 1'b1, c == dn};
  endfunction

  task automatic do_cycle(input bit s, input bit r, input logic [3:0] q);
    if (r) begin
      while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
      free_from = cyc + 1;
`ifdef INIT_REQ_CNT_EN
      model_iter = 0;
`endif
    end else if (s && cyc >= free_from) begin
      int dn = cyc + 4 + (int'(q) + 1) * L;
      for (int c = cyc + 1; c <= dn; c++) begin
        exp_t e;
        e.cyc = c;
        e.vec = exp_vec(c, cyc, int'(q));
        sb.push_back(e);
      end
      free_from = dn + 1;
`ifdef INIT_REQ_CNT_EN
      model_iter++;
`endif
    end
    if (s && !busy) begin
      decMode = 1'($urandom);
      decNum  = 4'(1 << $urandom_range(0, 3));
    end
    rst   = r;
    start = s;
    q_up  = q;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_vec = {fpu_req, bpu_req, tail, beta, tail_dly, alpha, alpha_dly,
                 fpu_load, bpu_load, busy, done};
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_cycle: entry for cycle %0d never compared (now %0d)", sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (mon_vec !== e.vec) begin
          errors++;
          $display("FAIL outputs cycle %0d: got %b required %b", cyc, mon_vec, e.vec);
        end
      end else if (mon_vec !== 11'd0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output cycle %0d: got %b required 0", cyc, mon_vec);
      end
    end
  end

  initial begin
    int t0;
    repeat (3) do_cycle(1'b0, 1'b1, 4'd0);
    #2;
    checks++;
    if ({fpu_req, bpu_req, tail, beta, tail_dly, alpha, alpha_dly, fpu_load, bpu_load, busy, done} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: got outputs nonzero, required 0");
    end
`ifdef INIT_REQ_CNT_EN
    checks++;
    if (iter_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_iter_cnt: got %0d required 0", iter_cnt);
    end
`endif
    mon_en = 1'b1;

    // Basic two-window run with an ignored mid-run start and a restart right after done.
    t0 = cyc;
    do_cycle(1'b1, 1'b0, 4'd1);
    repeat (4) do_cycle(1'b0, 1'b0, 4'd1);
    do_cycle(1'b1, 1'b0, 4'd1);
    while (cyc < t0 + 12) do_cycle(1'b0, 1'b0, 4'd1);
    do_cycle(1'b1, 1'b0, 4'd1);
    do_cycle(1'b1, 1'b0, 4'd1);
    repeat (20) do_cycle(1'b0, 1'b0, 4'd1);

    // Single-window run.
    do_cycle(1'b1, 1'b0, 4'd0);
    repeat (12) do_cycle(1'b0, 1'b0, 4'd0);

    // Abort mid-run, then a reset coinciding with start.
    t0 = cyc;
    do_cycle(1'b1, 1'b0, 4'd1);
    while (cyc < t0 + 6) do_cycle(1'b0, 1'b0, 4'd1);
    do_cycle(1'b0, 1'b1, 4'd1);
    repeat (15) do_cycle(1'b0, 1'b0, 4'd1);
    do_cycle(1'b1, 1'b1, 4'd2);
    repeat (5) do_cycle(1'b0, 1'b0, 4'd2);

    // Random traffic.
    for (int i = 0; i < 2500; i++) begin
      logic [3:0] q;
      q = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) q = 4'($urandom_range(0, 15));
      do_cycle($urandom_range(0, 5) == 0, $urandom_range(0, 149) == 0, q);
    end
    repeat (100) do_cycle(1'b0, 1'b0, 4'd0);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb.size());
    end
`ifdef INIT_REQ_CNT_EN
    checks++;
    if (iter_cnt !== 16'(model_iter)) begin
      errors++;
      $display("FAIL iter_cnt: got %0d required %0d", iter_cnt, model_iter);
    end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
